// File: rtl/lsu_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_apb_bridge
// Purpose  : RV32I data-bus to APB bridge with stall, byte lanes, load
//            extension, access timeout and error completion.
// Option   : MISALIGN_TRAP_EN - misaligned requests error out instead of
//            being aligned down.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_out,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_to_last = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit c_to_en = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait;
  logic              r_store;
  logic [2:0]        r_func3;
  logic [1:0]        r_lane;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [3:0]        r_pstrb;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;

  logic        w_req;
  logic        w_bad_code;
  logic        w_misalign;
  logic        w_invalid;
  logic        w_start;
  logic [1:0]  w_lane;
  logic [3:0]  w_strb;
  logic [31:0] w_wlanes;
  logic        w_acc;
  logic        w_to;
  logic        w_idle_err;
  logic        w_done_acc;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode in IDLE: legality, lane and strobe selection.
  always_comb begin
    w_req      = req_load | req_store;
    w_bad_code = (req_load & req_store) || (func3 == 3'b011) || (func3[2:1] == 2'b11) ||
                 (req_store && func3[2]);
    w_misalign = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
    w_invalid  = w_bad_code | w_misalign;
    w_lane     = addr[1:0];
`else
    w_invalid  = w_bad_code;
    w_lane     = w_misalign ? {addr[1] & ~func3[1], 1'b0} : addr[1:0];
`endif
    w_start    = (r_state == S_IDLE) && w_req && !w_invalid;

    w_strb = 4'b0000;
    if (req_store) begin
      case (func3[1:0])
        2'b00:   w_strb = 4'b0001 << w_lane;
        2'b01:   w_strb = w_lane[1] ? 4'b1100 : 4'b0011;
        default: w_strb = 4'b1111;
      endcase
    end

    case (func3[1:0])
      2'b00:   w_wlanes = {4{wdata[7:0]}};
      2'b01:   w_wlanes = {2{wdata[15:0]}};
      default: w_wlanes = wdata;
    endcase
  end

  // Load lane extraction and extension from the captured width code.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = prdata[7:0];
      2'd1:    w_byte = prdata[15:8];
      2'd2:    w_byte = prdata[23:16];
      default: w_byte = prdata[31:24];
    endcase
    w_half = r_lane[1] ? prdata[31:16] : prdata[15:0];
    case (r_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = prdata;
    endcase
  end

  always_comb begin
    w_acc      = (r_state == S_ACCESS);
    w_to       = c_to_en && w_acc && !pready && (r_wait == c_to_last);
    w_idle_err = (r_state == S_IDLE) && w_req && w_invalid;
    w_done_acc = w_acc && (pready || w_to);
  end

  assign done      = !rst && (w_idle_err || w_done_acc);
  assign err       = !rst && (w_idle_err || (w_acc && (pready ? pslverr : w_to)));
  assign rdata_out = (!rst && w_acc && pready && !pslverr && !r_store) ? w_load : 32'd0;
  assign stall     = w_req & ~done;

  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign pstrb   = r_pstrb;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_store   <= 1'b0;
      r_func3   <= 3'b000;
      r_lane    <= 2'b00;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= 4'b0000;
      r_paddr   <= '0;
      r_pwdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_SETUP;
            r_store  <= req_store;
            r_func3  <= func3;
            r_lane   <= w_lane;
            r_psel   <= 1'b1;
            r_pwrite <= req_store;
            r_pstrb  <= w_strb;
            r_paddr  <= {addr[ADDR_W-1:2], 2'b00};
            r_pwdata <= w_wlanes;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_wait    <= '0;
        end
        S_ACCESS: begin
          if (w_done_acc) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pstrb   <= 4'b0000;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_apb_bridge
// Purpose  : Transaction-level model and per-cycle comparison for lsu_apb_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_apb_bridge;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        req_load, req_store;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_out;
  logic        stall, done, err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  lsu_apb_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_load(req_load), .req_store(req_store), .func3(func3),
    .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
    .stall(stall), .done(done), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        chk_en = 1'b0;
  logic        chk_data = 1'b0;
  logic        e_psel, e_penable, e_pwrite, e_done, e_err, e_stall;
  logic [3:0]  e_pstrb;
  logic [31:0] e_paddr, e_pwdata, e_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("psel", psel, e_psel);
      chk("penable", penable, e_penable);
      chk("pwrite", pwrite, e_pwrite);
      chk("pstrb", pstrb, e_pstrb);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("rdata_out", rdata_out, e_rdata);
      chk("stall", stall, e_stall);
      if (e_psel || chk_data) chk("paddr", paddr, e_paddr);
      if (e_pwrite || chk_data) chk("pwdata", pwdata, e_pwdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_psel = 0; e_penable = 0; e_pwrite = 0; e_pstrb = 4'h0;
    e_done = 0; e_err = 0; e_rdata = 32'd0; e_stall = req_load | req_store;
    e_paddr = 32'd0; e_pwdata = 32'd0; chk_data = 1'b0;
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int ea, input logic [31:0] d);
    int sz;
    logic [31:0] v, mask;
    sz = m_size(f3);
    if (sz == 4) return d;
    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (d >> (8 * ea)) & mask;
    if (!f3[2] && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // One core memory instruction; returns during its completion cycle.
  task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int nwait, input logic slv, input logic [31:0] rd);
    logic bad, mis, rdy, tmo;
    int sz, la, ea;
    logic [31:0] rep;
    sz  = m_size(f3);
    la  = int'(a[1:0]);
    bad = (ld && st) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3 >= 3'd4);
    mis = (la % sz) != 0;
`ifdef MISALIGN_TRAP_EN
    bad = bad || mis;
`endif
    ea = la - (la % sz);
    for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % sz) +: 8];

    req_load = ld; req_store = st; func3 = f3; addr = a; wdata = wd;
    pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
    set_idle_exp();
    if (bad) begin
      e_done = 1; e_err = 1; e_stall = 0;
      return;
    end

    step();
    addr = $urandom; wdata = $urandom; pready = 1'($urandom_range(0, 1));
    e_psel = 1; e_penable = 0; e_pwrite = st;
    e_paddr = a & 32'hFFFF_FFFC;
    e_pstrb = st ? 4'((((1 << sz) - 1) << ea)) : 4'h0;
    e_pwdata = rep; e_done = 0; e_err = 0; e_rdata = 0; e_stall = 1;

    for (int k = 1; k <= TO + 1; k++) begin
      step();
      rdy = (k == nwait + 1);
      tmo = !rdy && (k == TO);
      pready = rdy;
      pslverr = rdy ? slv : 1'($urandom_range(0, 1));
      prdata = rdy ? rd : $urandom;
      addr = $urandom; wdata = $urandom;
      e_penable = 1;
      e_done  = rdy || tmo;
      e_err   = rdy ? slv : tmo;
      e_rdata = (rdy && !slv && ld) ? m_load(f3, ea, rd) : 32'd0;
      e_stall = !e_done;
      if (e_done) break;
    end
  endtask

  task automatic idle_cycle();
    step();
    req_load = 0; req_store = 0; pready = 1'($urandom_range(0, 1));
    set_idle_exp();
  endtask

  initial begin
    rst = 1; req_load = 0; req_store = 0; func3 = 0; addr = 0; wdata = 0;
    prdata = 0; pready = 0; pslverr = 0;

    step();
    set_idle_exp();
    chk_data = 1'b1;
    chk_en = 1'b1;
    step();
    rst = 0;
    set_idle_exp();

    // Directed cases with literal expectations.
    step();
    do_txn(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 0, 0, 0);
    #1;
    chk("pin_sw_paddr", paddr, 32'h1004);
    chk("pin_sw_pstrb", pstrb, 4'b1111);
    chk("pin_sw_pwrite", pwrite, 1'b1);
    chk("pin_sw_pwdata", pwdata, 32'hDEADBEEF);

    step();
    do_txn(1, 0, 3'b000, 32'h2003, 0, 1, 0, 32'h80FF_FF7F);
    #1 chk("pin_lb", rdata_out, 32'hFFFF_FF80);
    step();
    do_txn(1, 0, 3'b100, 32'h2003, 0, 0, 0, 32'h80FF_FF7F);
    #1 chk("pin_lbu", rdata_out, 32'h0000_0080);
    step();
    do_txn(1, 0, 3'b001, 32'h2002, 0, 0, 0, 32'h8001_0000);
    #1 chk("pin_lh", rdata_out, 32'hFFFF_8001);
    step();
    do_txn(0, 1, 3'b000, 32'h3002, 32'h0000_00A5, 0, 0, 0);
    #1;
    chk("pin_sb_pstrb", pstrb, 4'b0100);
    chk("pin_sb_pwdata", pwdata, 32'hA5A5_A5A5);
    step();
    do_txn(0, 1, 3'b001, 32'h3002, 32'h0000_1234, 0, 0, 0);
    #1;
    chk("pin_sh_pstrb", pstrb, 4'b1100);
    chk("pin_sh_pwdata", pwdata, 32'h1234_1234);
    step();
    do_txn(1, 0, 3'b010, 32'h3008, 0, TO, 0, 32'h1111_1111);
    #1;
    chk("pin_to_done", done, 1'b1);
    chk("pin_to_err", err, 1'b1);
    chk("pin_to_rdata", rdata_out, 32'd0);
    step();
    do_txn(1, 0, 3'b010, 32'h300C, 0, 3, 1, 32'h2222_2222);
    #1 chk("pin_slverr_err", err, 1'b1);
    step();
    do_txn(1, 0, 3'b010, 32'h4002, 0, 0, 0, 32'hCAFE_F00D);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("pin_mis_err", err, 1'b1);
    chk("pin_mis_psel", psel, 1'b0);
`else
    chk("pin_mis_paddr", paddr, 32'h4000);
    chk("pin_mis_err", err, 1'b0);
    chk("pin_mis_rdata", rdata_out, 32'hCAFE_F00D);
`endif
    idle_cycle();

    // Reset while ACCESS waits on a slow slave.
    step();
    req_load = 1; req_store = 0; func3 = 3'b010; addr = 32'h5000; pready = 0;
    set_idle_exp();
    step();
    e_psel = 1; e_paddr = 32'h5000; e_stall = 1;
    step();
    e_penable = 1;
    step();
    rst = 1;
    step();
    rst = 0; req_load = 0;
    set_idle_exp();
    chk_data = 1'b1;
    step();
    do_txn(1, 0, 3'b010, 32'h6000, 0, 0, 0, 32'h0BAD_F00D);
    #1 chk("pin_after_rst", rdata_out, 32'h0BAD_F00D);

    // Randomized transactions, mixed back-to-back and spaced.
    for (int t = 0; t < 300; t++) begin
      int op, r, nw;
      logic ld, st;
      op = $urandom_range(0, 9);
      ld = (op <= 5);
      st = (op == 0) || (op >= 6);
      r  = $urandom_range(0, 19);
      nw = (r < 14) ? (r % 5) : (r < 17) ? TO - 1 : TO;
      if ($urandom_range(0, 1) == 1) idle_cycle();
      step();
      do_txn(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, nw,
             ($urandom_range(0, 3) == 0), $urandom);
    end

    idle_cycle();
    idle_cycle();
    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
